// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
package hazard_pkg;

    // Multiply sequencer states
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MUL  = 1'b1;

    // Operand-forwarding selects for the Execute-stage ALU inputs
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Memory-stage result is younger than Writeback, so it wins on a tie.
    function automatic logic [1:0] fwdSel(
        input logic [3:0] ra,
        input logic [3:0] wa3M,
        input logic [3:0] wa3W,
        input logic       regWriteM,
        input logic       regWriteW
    );
        if (regWriteM && (wa3M == ra))      return FWD_MEM;
        else if (regWriteW && (wa3W == ra)) return FWD_WB;
        else                                return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_unit_mul_seq.sv
// Multi-cycle multiply sequencer: holds the op in Execute for MUL_CYCLES
// cycles, freezing in place while data memory is waiting.
module mul_seq
    import hazard_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic mulStart,
    input  logic freeze,
    output logic MulStall,
    output logic MulBusy,
    output logic MulDoneE
);

    // The start cycle and the done cycle are both spent in Execute, hence -2.
    localparam int               LOAD_VAL = (MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_VAL);

    logic [0:0]       state, nextState;
    logic [CNT_W-1:0] cnt, nextCnt;

    assign MulBusy = (state == MUL);

    // Next-state / stall / done decode; a frozen pipe holds the count.
    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        MulStall  = 1'b0;
        MulDoneE  = 1'b0;
        case (state)
            IDLE: begin
                if (mulStart) begin
                    if (MUL_CYCLES > 1) begin
                        // Start is accepted even under freeze; only decrements wait.
                        MulStall  = 1'b1;
                        nextState = MUL;
                        nextCnt   = CNT_LOAD;
                    end else if (freeze) begin
                        MulStall = 1'b1;
                    end else begin
                        MulDoneE = 1'b1;
                    end
                end
            end
            MUL: begin
                if (freeze) begin
                    MulStall = 1'b1;
                end else if (cnt != '0) begin
                    MulStall = 1'b1;
                    nextCnt  = cnt - 1'b1;
                end else begin
                    MulDoneE  = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
        if (reset) begin
            MulStall = 1'b0;
            MulDoneE = 1'b0;
        end
    end

    // State and counter registers; reset abandons any op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard/sequencing controller for the 5-stage core: forwarding selects,
// stall/flush strobes, multiply sequencing and a stall-cycle counter.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 4,
    parameter int PERF_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        RA1D,
    input  logic [3:0]        RA2D,
    input  logic [3:0]        RA1E,
    input  logic [3:0]        RA2E,
    input  logic [3:0]        WA3E,
    input  logic [3:0]        WA3M,
    input  logic [3:0]        WA3W,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemToRegE,
    input  logic              PCSrcD,
    input  logic              PCSrcE,
    input  logic              PCSrcM,
    input  logic              PCSrcW,
    input  logic              BranchTakenE,
    input  logic              MulStartE,
    input  logic              MemReqM,
    input  logic              MemReadyM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              FlushW,
    output logic              MulBusy,
    output logic              MulDoneE,
    output logic [PERF_W-1:0] StallCnt
);

    logic ldStall, pcPend, memStall, mulStall;

    assign ldStall  = MemToRegE & ((RA1D == WA3E) | (RA2D == WA3E));
    assign pcPend   = PCSrcD | PCSrcE | PCSrcM;
    assign memStall = MemReqM & ~MemReadyM;

    mul_seq #(
        .MUL_CYCLES (MUL_CYCLES),
        .CNT_W      (CNT_W)
    ) uMulSeq (
        .clk      (clk),
        .reset    (reset),
        .mulStart (MulStartE),
        .freeze   (memStall),
        .MulStall (mulStall),
        .MulBusy  (MulBusy),
        .MulDoneE (MulDoneE)
    );

    // Forwarding plus the stall/flush priority mux: memory wait > multiply > normal.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        FlushW    = 1'b0;
        if (!reset) begin
            ForwardAE = fwdSel(RA1E, WA3M, WA3W, RegWriteM, RegWriteW);
            ForwardBE = fwdSel(RA2E, WA3M, WA3W, RegWriteM, RegWriteW);
            if (memStall) begin
                // Whole pipe frozen; Writeback retires into a bubble.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (mulStall) begin
                // Multiply occupies Execute; Memory receives bubbles.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else begin
                StallF = ldStall | pcPend;
                StallD = ldStall;
                FlushD = pcPend | PCSrcW | BranchTakenE;
                FlushE = ldStall | BranchTakenE;
            end
        end
    end

    // Saturating count of fetch-stall cycles.
    always_ff @(posedge clk) begin
        if (reset)
            StallCnt <= '0;
        else if (StallF && (StallCnt != '1))
            StallCnt <= StallCnt + 1'b1;
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench: stimulus pushes expected outputs into a queue,
// a negedge monitor pops and compares against the DUT.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic        RegWriteM, RegWriteW, MemToRegE;
    logic        PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
    logic        MulStartE, MemReqM, MemReadyM;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushM, FlushW;
    logic        MulBusy, MulDoneE;
    logic [15:0] StallCnt;

    typedef struct {
        string       nm;
        logic [13:0] v;
        bit          chkCnt;
        logic [15:0] cnt;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    hazard_unit #(.MUL_CYCLES(4), .CNT_W(4), .PERF_W(16)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemToRegE(MemToRegE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .MulBusy(MulBusy), .MulDoneE(MulDoneE), .StallCnt(StallCnt)
    );

    // Pack: fwdA, fwdB, stall {F,D,E,M}, flush {D,E,M,W}, busy, done
    function automatic logic [13:0] v(input logic [1:0] fa, input logic [1:0] fb,
                                      input logic [3:0] s, input logic [3:0] f,
                                      input logic b, input logic d);
        return {fa, fb, s, f, b, d};
    endfunction

    task automatic chk(input string nm, input logic [13:0] e,
                       input bit cc = 1'b0, input logic [15:0] ce = 16'h0);
        item_t it;
        it.nm = nm; it.v = e; it.chkCnt = cc; it.cnt = ce;
        q.push_back(it);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0; WA3E = 0; WA3M = 0; WA3W = 0;
        RegWriteM = 0; RegWriteW = 0; MemToRegE = 0;
        PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0; BranchTakenE = 0;
        MulStartE = 0; MemReqM = 0; MemReadyM = 0;
    endtask

    // Monitor: outputs are combinational every cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t it;
            logic [13:0] act;
            it  = q.pop_front();
            act = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                   FlushD, FlushE, FlushM, FlushW, MulBusy, MulDoneE};
            checks++;
            if (act !== it.v) begin
                errors++;
                $display("FAIL %s: outputs got %b want %b", it.nm, act, it.v);
            end
            if (it.chkCnt) begin
                checks++;
                if (StallCnt !== it.cnt) begin
                    errors++;
                    $display("FAIL %s: StallCnt got %h want %h", it.nm, StallCnt, it.cnt);
                end
            end
        end
    end

    initial begin
        clearIn();
        reset = 1'b1;
        tick();
        chk("reset", v(0, 0, 4'b0000, 4'b0000, 0, 0), 1, 16'd0);
        tick();
        reset = 1'b0;

        // Forwarding priority
        WA3M = 3; RegWriteM = 1; WA3W = 3; RegWriteW = 1; RA1E = 3;
        chk("fwd_mem", v(2'b10, 2'b00, 4'b0000, 4'b0000, 0, 0), 1, 16'd0);
        tick();
        RegWriteM = 0;
        chk("fwd_wb", v(2'b01, 2'b00, 4'b0000, 4'b0000, 0, 0));
        tick();
        RA1E = 4; RA2E = 3;
        chk("fwd_rf_b_wb", v(2'b00, 2'b01, 4'b0000, 4'b0000, 0, 0));
        tick();
        RegWriteM = 1;
        chk("fwd_b_mem", v(2'b00, 2'b10, 4'b0000, 4'b0000, 0, 0));
        tick();
        clearIn();

        // Load-use stall
        MemToRegE = 1; WA3E = 5; RA2D = 5;
        chk("ldstall", v(0, 0, 4'b1100, 4'b0100, 0, 0), 1, 16'd0);
        tick();
        clearIn();
        chk("ld_clear", v(0, 0, 4'b0000, 4'b0000, 0, 0), 1, 16'd1);
        tick();

        // Branch / PC redirect
        BranchTakenE = 1;
        chk("branch", v(0, 0, 4'b0000, 4'b1100, 0, 0));
        tick();
        BranchTakenE = 0; PCSrcD = 1;
        chk("pcsrcD", v(0, 0, 4'b1000, 4'b1000, 0, 0), 1, 16'd1);
        tick();
        PCSrcD = 0; PCSrcW = 1;
        chk("pcsrcW", v(0, 0, 4'b0000, 4'b1000, 0, 0), 1, 16'd2);
        tick();
        clearIn();

        // Plain multiply, branch ignored on start cycle
        MulStartE = 1; BranchTakenE = 1;
        chk("mul_t0", v(0, 0, 4'b1110, 4'b0010, 0, 0));
        tick();
        BranchTakenE = 0;
        chk("mul_t1", v(0, 0, 4'b1110, 4'b0010, 1, 0));
        tick();
        chk("mul_t2", v(0, 0, 4'b1110, 4'b0010, 1, 0));
        tick();
        chk("mul_t3_done", v(0, 0, 4'b0000, 4'b0000, 1, 1));
        tick();
        MulStartE = 0;
        chk("mul_t4", v(0, 0, 4'b0000, 4'b0000, 0, 0), 1, 16'd5);
        tick();

        // Multiply frozen by memory wait while cnt=1
        MulStartE = 1;
        chk("mm_t0", v(0, 0, 4'b1110, 4'b0010, 0, 0));
        tick();
        chk("mm_t1", v(0, 0, 4'b1110, 4'b0010, 1, 0));
        tick();
        MemReqM = 1; MemReadyM = 0;
        chk("mm_mem1", v(0, 0, 4'b1111, 4'b0001, 1, 0));
        tick();
        chk("mm_mem2", v(0, 0, 4'b1111, 4'b0001, 1, 0));
        tick();
        MemReqM = 0;
        chk("mm_resume", v(0, 0, 4'b1110, 4'b0010, 1, 0));
        tick();
        chk("mm_done", v(0, 0, 4'b0000, 4'b0000, 1, 1));
        tick();
        MulStartE = 0;
        chk("mm_idle", v(0, 0, 4'b0000, 4'b0000, 0, 0), 1, 16'd10);
        tick();

        // Start coincident with memory wait
        MulStartE = 1; MemReqM = 1;
        chk("sm_t0", v(0, 0, 4'b1111, 4'b0001, 0, 0));
        tick();
        chk("sm_t1", v(0, 0, 4'b1111, 4'b0001, 1, 0));
        tick();
        MemReqM = 0;
        chk("sm_t2", v(0, 0, 4'b1110, 4'b0010, 1, 0));
        tick();
        chk("sm_t3", v(0, 0, 4'b1110, 4'b0010, 1, 0));
        tick();
        chk("sm_done", v(0, 0, 4'b0000, 4'b0000, 1, 1));
        tick();
        MulStartE = 0;
        chk("sm_idle", v(0, 0, 4'b0000, 4'b0000, 0, 0), 1, 16'd14);
        tick();

        // Reset mid-multiply: outputs gated, op abandoned
        MulStartE = 1;
        chk("rm_t0", v(0, 0, 4'b1110, 4'b0010, 0, 0));
        tick();
        reset = 1; RegWriteM = 1; BranchTakenE = 1;
        chk("rm_reset", v(0, 0, 4'b0000, 4'b0000, 1, 0));
        tick();
        reset = 0; MulStartE = 0; RegWriteM = 0; BranchTakenE = 0;
        chk("rm_after", v(0, 0, 4'b0000, 4'b0000, 0, 0), 1, 16'd0);
        tick();
        chk("rm_after2", v(0, 0, 4'b0000, 4'b0000, 0, 0));
        tick();

        // Counter saturation
        PCSrcD = 1;
        chk("sat_first", v(0, 0, 4'b1000, 4'b1000, 0, 0), 1, 16'd0);
        for (int i = 0; i < 70000; i++) tick();
        PCSrcD = 0;
        chk("sat", v(0, 0, 4'b0000, 4'b0000, 0, 0), 1, 16'hFFFF);
        tick();
        tick();

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: pending got %0d want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Central hazard/sequencing controller for the 5-stage pipelined core (Fetch, Decode, Execute, Memory, Writeback).
- Generates operand-forwarding selects, per-stage stall and flush strobes, and sequences multi-cycle multiply ops held in Execute.
- Freezes the pipe on data-memory wait states and keeps a saturating stall-cycle counter.
- Sits beside the controller/datapath; its StallD/FlushD/FlushE drive the pipeline-register enables and clears.

Parameters:
- MUL_CYCLES, 4, total cycles a multiply occupies Execute (1..15).
- CNT_W, 4, width of the multiply down-counter.
- PERF_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- RA1D, RA2D  in  4 each  source registers of the instruction in Decode
- RA1E, RA2E  in  4 each  source registers of the instruction in Execute
- WA3E, WA3M, WA3W  in  4 each  destination registers in Execute, Memory and Writeback
- RegWriteM, RegWriteW  in  1  register-write enables in Memory and Writeback
- MemToRegE  in  1  a load is in Execute
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  PC write pending in Decode, Execute, Memory and Writeback
- BranchTakenE  in  1  branch resolved taken in Execute
- MulStartE  in  1  a multi-cycle multiply is in Execute
- MemReqM  in  1  load/store active in Memory
- MemReadyM  in  1  data memory acknowledge
- ForwardAE, ForwardBE  out  2 each  operand select: 00 register file, 01 Writeback result, 10 Memory ALU result
- StallF, StallD, StallE, StallM  out  1  hold the PC / pipeline register
- FlushD, FlushE, FlushM, FlushW  out  1  clear the pipeline register (bubble)
- MulBusy  out  1  multiply sequencer in MUL state
- MulDoneE  out  1  one-cycle pulse on the final multiply cycle
- StallCnt  out  PERF_W  saturating count of cycles with StallF=1

Behaviour:
- Forwarding (combinational):
  - ForwardAE=10 if RegWriteM and WA3M==RA1E.
  - Otherwise ForwardAE=01 if RegWriteW and WA3W==RA1E.
  - Otherwise ForwardAE=00. Memory takes priority over Writeback.
  - ForwardBE uses the same rules with RA2E.
- LdStall = MemToRegE & (RA1D==WA3E | RA2D==WA3E).
- PCPend = PCSrcD | PCSrcE | PCSrcM.
- MemStall = MemReqM & ~MemReadyM.
- Multiply sequencer (states IDLE, MUL; counter cnt):
  - IDLE & MulStartE & MUL_CYCLES>1: MulStall=1; cnt<=MUL_CYCLES-2; go to MUL.
  - IDLE & MulStartE & MUL_CYCLES==1: MulDoneE=1, no stall.
  - MUL & cnt!=0: MulStall=1; cnt decrements.
  - MUL & cnt==0: MulStall=0; MulDoneE=1; go to IDLE.
  - The op therefore occupies Execute for exactly MUL_CYCLES cycles.
  - While MemStall=1, state and cnt hold, MulDoneE is suppressed, and MulStall is treated as 1.
- Output priority, highest first:
  - MemStall: StallF=StallD=StallE=StallM=1, FlushW=1, all other flushes 0.
  - MulStall: StallF=StallD=StallE=1, FlushM=1, StallM=0, FlushD=FlushE=FlushW=0.
  - Normal:
    - StallF = LdStall | PCPend.
    - StallD = LdStall.
    - FlushD = PCPend | PCSrcW | BranchTakenE.
    - FlushE = LdStall | BranchTakenE.
    - StallE=StallM=FlushM=FlushW=0.
- StallCnt increments each cycle StallF=1 and saturates at all-ones.
- Reset:
  - During reset, all stall/flush/forward outputs are 0 and MulDoneE=0.
  - Next cycle: state=IDLE, cnt=0, StallCnt=0, MulBusy=0.
  - Reset mid-MUL abandons the op; no MulDoneE is emitted.
- Simultaneous events:
  - MulStartE in the same cycle as MemStall: the start is latched and the counter is loaded, but its first decrement waits until MemStall drops.
  - BranchTakenE is ignored while MulStall or MemStall is active.

Decomposition:
- hazard_pkg: state encoding (IDLE, MUL); forward encodings FWD_RF=00, FWD_WB=01, FWD_MEM=10.
- Sub-module mul_seq: FSM plus down-counter, with an input freeze=MemStall and outputs MulStall, MulBusy, MulDoneE.
- Forwarding, priority mux and perf counter live in hazard_unit.

Test Plan:
- WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1, RA1E=3 -> ForwardAE=10. Drop RegWriteM -> 01. RA1E=4 -> 00.
- MemToRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for one cycle, FlushD=0.
- MulStartE at cycle t, MUL_CYCLES=4 -> StallE=1 and FlushM=1 in cycles t..t+2, MulDoneE=1 at t+3, MulBusy=1 at t+1..t+3.
- During MUL (cnt=1), MemReqM=1 with MemReadyM=0 for 2 cycles -> StallM=1 and FlushW=1 for those 2 cycles, cnt holds, MulDoneE is delayed by 2 cycles.
- BranchTakenE=1 with no other hazard -> FlushD=FlushE=1, StallD=0. PCSrcD=1 -> StallF=1, FlushD=1.
- Reset asserted at cycle t+1 of a multiply -> outputs 0, state IDLE, no MulDoneE. Then 70000 stall cycles -> StallCnt=16'hFFFF.
